bram_steer_array: RTL and testbench

BRAM_STEER_ARRAY -- requirements
Module: bram_steer_array

---
 rtl/bram_steer_array.sv | 142 ++++++++++++++
 tb/tb_bram_steer_array.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/bram_steer_array.sv
// bram_steer_array: loads a stream into LANES packed BRAMs (distribute or broadcast),
// then reads back DEPTH/PACK wide words, one lane group per output slice.
module bram_steer_array #(
    parameter int LANES = 4,
    parameter int DW    = 8,
    parameter int PACK  = 4,
    parameter int DEPTH = 2048
) (
    input  logic                        CLK,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        mode,
    input  logic [DW-1:0]               in_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic [LANES*PACK*DW-1:0]    out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        out_last,
    output logic [DW-1:0]               pass_data,
    output logic                        pass_valid,
    output logic                        busy,
    output logic                        complete
);
    localparam int NW = DEPTH / PACK;
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PW = $clog2(PACK);
    localparam int SW = (PACK > 1) ? PW : 1;
    localparam int WW = (NW > 1) ? $clog2(NW) : 1;
    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int CW = $clog2(LANES * DEPTH + 1);
    localparam int RW = $clog2(NW + 1);
    localparam int OW = LANES * PACK * DW;

    typedef enum logic [1:0] {IDLE, LOAD, READ} state_t;

    state_t          r_state;
    logic            r_mode;
    logic            r_complete;
    logic            r_pass_valid;
    logic [DW-1:0]   r_pass_data;
    logic [CW-1:0]   r_wcnt;
    logic [RW-1:0]   r_rcnt;
    logic [OW-1:0]   r_buf [2];
    logic [1:0]      r_blast;
    logic            r_wp;
    logic            r_rp;
    logic [1:0]      r_cnt;

    logic            w_acc;
    logic            w_last_in;
    logic            w_issue;
    logic            w_pop;
    logic            w_rlast;
    logic [AW-1:0]   w_off;
    logic [SW-1:0]   w_slot;
    logic [WW-1:0]   w_waddr;
    logic [WW-1:0]   w_raddr;
    logic [LW-1:0]   w_lane;
    logic [OW-1:0]   w_rword;

    assign w_acc     = in_valid && (r_state == LOAD);
    assign w_off     = AW'(r_wcnt);
    assign w_lane    = LW'(r_wcnt >> AW);
    assign w_slot    = (PACK > 1) ? SW'(w_off) : '0;
    assign w_waddr   = WW'(w_off >> PW);
    assign w_last_in = r_wcnt == (r_mode ? CW'(DEPTH - 1) : CW'(LANES * DEPTH - 1));
    assign w_pop     = out_valid && out_ready;
    // a read may be issued whenever the buffer will have a free entry at the next edge
    assign w_issue   = (r_state == READ) && (r_rcnt != RW'(NW)) && (r_cnt != 2'd2 || w_pop);
    assign w_raddr   = WW'(r_rcnt);
    assign w_rlast   = r_rcnt == RW'(NW - 1);

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        for (genvar s = 0; s < PACK; s++) begin : g_slot
            logic [DW-1:0] r_mem [NW];
            always_ff @(posedge CLK)
                if (w_acc && (r_mode || w_lane == LW'(l)) && w_slot == SW'(s))
                    r_mem[w_waddr] <= in_data;
            assign w_rword[(l*PACK+s)*DW +: DW] = r_mem[w_raddr];
        end
    end

    always_ff @(posedge CLK) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_mode       <= 1'b0;
            r_complete   <= 1'b0;
            r_pass_valid <= 1'b0;
            r_pass_data  <= '0;
            r_wcnt       <= '0;
            r_rcnt       <= '0;
            r_buf[0]     <= '0;
            r_buf[1]     <= '0;
            r_blast      <= '0;
            r_wp         <= 1'b0;
            r_rp         <= 1'b0;
            r_cnt        <= '0;
        end else begin
            r_complete   <= 1'b0;
            r_pass_valid <= w_acc;
            if (w_acc)
                r_pass_data <= in_data;
            case (r_state)
                IDLE: if (start) begin
                    r_state <= LOAD;
                    r_mode  <= mode;
                    r_wcnt  <= '0;
                    r_rcnt  <= '0;
                end
                LOAD: if (w_acc) begin
                    r_wcnt <= r_wcnt + 1'b1;
                    if (w_last_in)
                        r_state <= READ;
                end
                READ: if (w_pop && r_blast[r_rp]) begin
                    r_state    <= IDLE;
                    r_complete <= 1'b1;
                end
                default: r_state <= IDLE;
            endcase
            if (w_issue) begin
                r_buf[r_wp]   <= w_rword;
                r_blast[r_wp] <= w_rlast;
                r_wp          <= ~r_wp;
                r_rcnt        <= r_rcnt + 1'b1;
            end
            if (w_pop)
                r_rp <= ~r_rp;
            r_cnt <= r_cnt + {1'b0, w_issue} - {1'b0, w_pop};
        end
    end

    assign in_ready   = r_state == LOAD;
    assign busy       = r_state != IDLE;
    assign complete   = r_complete;
    assign out_valid  = r_cnt != 2'd0;
    assign out_data   = r_buf[r_rp];
    assign out_last   = out_valid && r_blast[r_rp];
    assign pass_data  = r_pass_data;
    assign pass_valid = r_pass_valid;
endmodule

// File: tb/tb_bram_steer_array.sv
// tb_bram_steer_array: directed runs with a word scoreboard, backpressure, gaps, reset and start pokes.
module tb_bram_steer_array;
    localparam int LANES = 2, DW = 8, PACK = 4, DEPTH = 8;
    localparam int NW = DEPTH / PACK;
    localparam int OW = LANES * PACK * DW;

    logic          CLK = 1'b0, rst = 1'b0, start = 1'b0, mode = 1'b0;
    logic          in_valid = 1'b0, out_ready = 1'b1;
    logic [DW-1:0] in_data = '0;
    logic          in_ready, out_valid, out_last, pass_valid, busy, complete;
    logic [OW-1:0] out_data;
    logic [DW-1:0] pass_data;

    always #5 CLK = ~CLK;

    bram_steer_array #(.LANES(LANES), .DW(DW), .PACK(PACK), .DEPTH(DEPTH)) dut (
        .CLK(CLK), .rst(rst), .start(start), .mode(mode), .in_data(in_data),
        .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
        .pass_data(pass_data), .pass_valid(pass_valid), .busy(busy), .complete(complete)
    );

    int            n_checks = 0, n_err = 0;
    int            n_words = 0, n_complete = 0, n_pass = 0;
    logic [OW:0]   exp_q [$];
    logic [DW-1:0] pass_q [$];
    bit            done_flag = 0, exp_cpl = 0, prev_stall = 0, prev_acc = 0, bp_en = 0;
    logic [OW-1:0] prev_data = '0;
    logic          prev_last = 1'b0;
    int            stall_left = 0;

    task automatic chk(input string tag, input logic [OW-1:0] got, input logic [OW-1:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // scoreboard/monitor: samples at negedge, the values the next rising edge will see
    always @(negedge CLK) begin
        logic [OW:0] e;
        chk("complete", OW'(complete), OW'(exp_cpl));
        exp_cpl = 0;
        if (prev_stall && rst) begin
            chk("hold_valid", OW'(out_valid), OW'(1'b1));
            chk("hold_data", out_data, prev_data);
            chk("hold_last", OW'(out_last), OW'(prev_last));
        end
        chk("pass_valid", OW'(pass_valid), OW'(prev_acc));
        if (prev_acc && pass_q.size() != 0)
            chk("pass_data", OW'(pass_data), OW'(pass_q.pop_front()));
        if (pass_valid) n_pass++;
        if (complete) n_complete++;
        prev_acc = rst && in_valid && in_ready;
        if (prev_acc) pass_q.push_back(in_data);
        prev_stall = rst && out_valid && !out_ready;
        prev_data = out_data;
        prev_last = out_last;
        if (rst && out_valid && out_ready) begin
            chk("sb_nonempty", OW'(exp_q.size() != 0), OW'(1'b1));
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("word", out_data, e[OW-1:0]);
                chk("last", OW'(out_last), OW'(e[OW]));
                n_words++;
                if (e[OW]) begin
                    exp_cpl = 1;
                    done_flag = 1;
                end
            end
        end
    end

    initial forever begin
        @(posedge CLK); #1;
        if (!bp_en) out_ready = 1'b1;
        else if (stall_left > 0 && out_valid) begin
            out_ready = 1'b0;
            stall_left--;
        end else out_ready = 1'($urandom_range(0, 1));
    end

    task automatic push_exp(input bit m, input int base);
        for (int w = 0; w < NW; w++) begin
            logic [OW:0] e = '0;
            for (int l = 0; l < LANES; l++)
                for (int s = 0; s < PACK; s++)
                    e[(l*PACK+s)*DW +: DW] = DW'(base + (m ? w*PACK+s : l*DEPTH+w*PACK+s));
            e[OW] = (w == NW - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic feed(input bit m, input int base, input int n, input bit gap, input bit poke, output int acc);
        start = 1'b1; mode = m;
        @(posedge CLK); #1;
        start = 1'b0;
        acc = 0;
        for (int cyc = 0; cyc < 400 && acc < n; cyc++) begin
            in_valid = gap ? ($urandom_range(0, 2) != 0) : 1'b1;
            in_data  = DW'(base + acc);
            start    = poke && cyc == 3;
            mode     = (poke && cyc == 3) ? ~m : m;
            @(negedge CLK);
            if (in_valid && in_ready) acc++;
            @(posedge CLK); #1;
        end
        in_valid = 1'b0; start = 1'b0; mode = m;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_in_ready"}, OW'(in_ready), '0);
        chk({tag, "_out_valid"}, OW'(out_valid), '0);
        chk({tag, "_out_last"}, OW'(out_last), '0);
        chk({tag, "_busy"}, OW'(busy), '0);
        chk({tag, "_complete"}, OW'(complete), '0);
    endtask

    task automatic run(input bit m, input int base, input bit gap, input bit bp, input bit poke);
        int acc, w0, c0, p0, n, cyc;
        n = m ? DEPTH : LANES * DEPTH;
        exp_q.delete();
        push_exp(m, base);
        done_flag = 0; w0 = n_words; c0 = n_complete; p0 = n_pass;
        bp_en = bp; stall_left = 5;
        feed(m, base, n, gap, poke, acc);
        chk("accepted", OW'(acc), OW'(n));
        in_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge CLK);
            chk("in_ready_drop", OW'(in_ready), '0);
            chk("first_valid", OW'(out_valid), OW'(i == 1));
            @(posedge CLK); #1;
        end
        in_valid = 1'b0;
        for (cyc = 0; cyc < 300 && !done_flag; cyc++) begin
            start = poke;
            @(posedge CLK); #1;
        end
        start = 1'b0;
        chk("run_done", OW'(done_flag), OW'(1'b1));
        repeat (2) begin @(posedge CLK); #1; end
        @(negedge CLK);
        check_idle("after_run");
        @(posedge CLK); #1;
        chk("words", OW'(n_words - w0), OW'(NW));
        chk("completes", OW'(n_complete - c0), OW'(1));
        chk("pass_count", OW'(n_pass - p0), OW'(n));
        chk("sb_empty", OW'(exp_q.size()), '0);
        bp_en = 0;
    endtask

    initial begin
        int acc;
        rst = 1'b0;
        repeat (2) @(posedge CLK);
        #1 rst = 1'b1;
        @(negedge CLK);
        check_idle("reset");
        chk("reset_out_data", out_data, '0);
        chk("reset_pass_data", OW'(pass_data), '0);
        @(posedge CLK); #1;

        run(0, 'h00, 0, 0, 0);
        run(1, 'h10, 0, 0, 0);
        run(0, 'h00, 0, 1, 0);
        run(0, 'h00, 1, 0, 0);

        exp_q.delete();
        feed(0, 'h40, 5, 0, 0, acc);
        chk("partial_accepted", OW'(acc), OW'(5));
        rst = 1'b0;
        @(posedge CLK); #1;
        rst = 1'b1;
        @(negedge CLK);
        check_idle("midrun_reset");
        chk("midrun_pass_valid", OW'(pass_valid), '0);
        chk("midrun_out_data", out_data, '0);
        chk("midrun_pass_data", OW'(pass_data), '0);
        @(posedge CLK); #1;
        run(0, 'h00, 0, 0, 0);

        run(0, 'h00, 0, 0, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
